// File: rtl/sisc_pkg.sv
// Shared types and encodings for the SISC control sequencer.
package sisc_pkg;

    typedef enum logic [3:0] {
        StStart0,
        StStart1,
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWb,
        StWb2,
        StHalt
    } state_e;

    localparam int unsigned OP_NOOP = 0;
    localparam int unsigned OP_LOD  = 1;
    localparam int unsigned OP_STR  = 2;
    localparam int unsigned OP_SWP  = 3;
    localparam int unsigned OP_BRA  = 4;
    localparam int unsigned OP_BRR  = 5;
    localparam int unsigned OP_BNE  = 6;
    localparam int unsigned OP_BNR  = 7;
    localparam int unsigned OP_ALU  = 8;
    localparam int unsigned OP_HLT  = 15;

    localparam int unsigned AM_IMM = 8;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_ABS = 2'd1;
    localparam logic [1:0] PC_REL = 2'd2;

endpackage

// File: rtl/br_cond.sv
// Branch-taken evaluation from the latched opcode, condition mask and status flags.
module br_cond
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned MM_W = 4
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [MM_W-1:0] i_mm,
    input  logic [MM_W-1:0] i_stat,
    output logic            o_taken
);

    logic w_hit;
    logic w_mm_zero;

    assign w_hit     = |(i_stat & i_mm);
    assign w_mm_zero = ~|i_mm;

    always_comb begin
        o_taken = 1'b0;
        case (32'(i_op))
            OP_BRA, OP_BRR: o_taken = w_mm_zero | w_hit;
            OP_BNE, OP_BNR: o_taken = ~w_hit;
            default:        o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the SISC datapath.
// Optional memory-ready stall with timeout is enabled by defining CTRL_MEM_WAIT_EN.
module ctrl_seq
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W     = 4,
    parameter int unsigned MM_W     = 4,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [MM_W-1:0]     mm,
    input  logic [MM_W-1:0]     stat,
    input  logic                mem_rdy,
    output logic                rf_we,
    output logic                wb_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_sel,
    output logic                pc_write,
    output logic                ir_load,
    output logic                mem_re,
    output logic                mem_we,
    output logic                swp_phase,
    output logic                halted,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    state_e          r_state;
    logic [OP_W-1:0] r_op;
    logic [MM_W-1:0] r_mm;

    logic       w_is_lod;
    logic       w_is_str;
    logic       w_is_swp;
    logic       w_is_alu;
    logic       w_is_abs;
    logic       w_is_mem;
    logic       w_taken;
    logic [1:0] w_alu_exec;

    assign w_is_lod = (32'(r_op) == OP_LOD);
    assign w_is_str = (32'(r_op) == OP_STR);
    assign w_is_swp = (32'(r_op) == OP_SWP);
    assign w_is_alu = (32'(r_op) == OP_ALU);
    assign w_is_abs = (32'(r_op) == OP_BRA) || (32'(r_op) == OP_BNE);
    assign w_is_mem = w_is_lod | w_is_str;

    br_cond #(
        .OP_W (OP_W),
        .MM_W (MM_W)
    ) u_br_cond (
        .i_op    (r_op),
        .i_mm    (r_mm),
        .i_stat  (stat),
        .o_taken (w_taken)
    );

    always_comb begin
        w_alu_exec = ALU_PASS;
        if (w_is_alu) begin
            w_alu_exec = (32'(r_mm) == AM_IMM) ? ALU_RI : ALU_RR;
        end else if (w_is_mem) begin
            w_alu_exec = ALU_RI;
        end
    end

`ifdef CTRL_MEM_WAIT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign err = r_err;
`else
    logic             w_unused_rdy;
    logic [CNT_W-1:0] w_unused_cnt;

    assign w_unused_rdy = mem_rdy;
    assign w_unused_cnt = '0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StStart0;
            r_op    <= '0;
            r_mm    <= '0;
`ifdef CTRL_MEM_WAIT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                StStart0:  r_state <= StStart1;
                StStart1:  r_state <= StFetch;
                StFetch:   r_state <= StDecode;
                StDecode: begin
                    r_op    <= opcode;
                    r_mm    <= mm;
                    r_state <= (32'(opcode) == OP_HLT) ? StHalt : StExecute;
                end
                StExecute: r_state <= StMem;
                StMem: begin
`ifdef CTRL_MEM_WAIT_EN
                    // A ready on the final allowed cycle still completes the access.
                    if (w_is_mem && !mem_rdy) begin
                        if (r_cnt == CNT_W'(WAIT_MAX - 1)) begin
                            r_state <= StHalt;
                            r_err   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= StWb;
                    end
`else
                    r_state <= StWb;
`endif
                end
                StWb:      r_state <= w_is_swp ? StWb2 : StFetch;
                StWb2:     r_state <= StFetch;
                StHalt:    r_state <= StHalt;
                default:   r_state <= StStart0;
            endcase
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        alu_op    = ALU_OP_W'(ALU_PASS);
        pc_sel    = PC_INC;
        pc_write  = 1'b0;
        ir_load   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        swp_phase = 1'b0;
        halted    = 1'b0;
        case (r_state)
            StFetch: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = PC_INC;
            end
            StExecute: begin
                alu_op = ALU_OP_W'(w_alu_exec);
                if (w_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = w_is_abs ? PC_ABS : PC_REL;
                end
            end
            StMem: begin
                alu_op = ALU_OP_W'(w_alu_exec);
                mem_re = w_is_lod;
                mem_we = w_is_str;
            end
            StWb: begin
                rf_we  = w_is_alu | w_is_lod | w_is_swp;
                wb_sel = w_is_lod;
            end
            StWb2: begin
                rf_we     = 1'b1;
                swp_phase = 1'b1;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-cycle expected outputs built from the instruction rules.
module tb_ctrl_seq;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic       rf_we;
        logic       wb_sel;
        logic [1:0] alu_op;
        logic [1:0] pc_sel;
        logic       pc_write;
        logic       ir_load;
        logic       mem_re;
        logic       mem_we;
        logic       swp_phase;
        logic       halted;
        logic       err;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic [3:0] mm = '0;
    logic [3:0] stat = '0;
    logic       mem_rdy = 1'b0;
    logic       rf_we, wb_sel, pc_write, ir_load, mem_re, mem_we, swp_phase, halted, err;
    logic [1:0] alu_op, pc_sel;

    ctrl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .mem_rdy   (mem_rdy),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .pc_sel    (pc_sel),
        .pc_write  (pc_write),
        .ir_load   (ir_load),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .swp_phase (swp_phase),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    outs_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    n_rfwe = 0;
    int    n_mem  = 0;
    int    cyc    = 0;
    logic  m_err  = 1'b0;

    always @(negedge clk) begin
        outs_t got;
        outs_t e;
        cyc++;
        got = '{rf_we, wb_sel, alu_op, pc_sel, pc_write, ir_load,
                mem_re, mem_we, swp_phase, halted, err};
        n_rfwe += int'(rf_we);
        n_mem  += int'(mem_re | mem_we);
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %b required %b", cyc, got, e);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic outs_t idle();
        outs_t e;
        e        = '0;
        e.alu_op = 2'b10;
        e.err    = m_err;
        return e;
    endfunction

    function automatic logic [1:0] alu_of(input int op, input int mmv);
        if (op == 8) return (mmv == 8) ? 2'b01 : 2'b00;
        if (op == 1 || op == 2) return 2'b01;
        return 2'b10;
    endfunction

    function automatic bit taken_of(input int op, input int mmv, input int st);
        if (op == 4 || op == 5) return (mmv == 0) || ((st & mmv) != 0);
        if (op == 6 || op == 7) return (st & mmv) == 0;
        return 1'b0;
    endfunction

    task automatic step(input outs_t e, input int op, input int mmv, input int st,
                        input logic rdy);
        @(posedge clk);
        #1;
        opcode  = 4'(op);
        mm      = 4'(mmv);
        stat    = 4'(st);
        mem_rdy = rdy;
        q.push_back(e);
    endtask

    task automatic reset_tail();
        @(posedge clk); #1; q.push_back(idle());
        @(posedge clk); #1; rst = 1'b0; q.push_back(idle());
        @(posedge clk); #1; q.push_back(idle());
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst   = 1'b1;
        m_err = 1'b0;
        q.push_back(idle());
        reset_tail();
    endtask

    task automatic hold_halt(input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            e        = idle();
            e.halted = 1'b1;
            step(e, 8, i, i, 1'b1);
        end
    endtask

    // One instruction; exp_rf/exp_mem are hand-counted rf_we and strobe cycles.
    task automatic run_instr(input int op, input int mmv, input int st, input int dly,
                             input int exp_rf, input int exp_mem_w, input int exp_mem_n);
        outs_t e;
        int    rf0, m0, nmem, exp_mem;
        bit    tmo;
        rf0  = n_rfwe;
        m0   = n_mem;
        nmem = 1;
        tmo  = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
        exp_mem = exp_mem_w;
        if (op == 1 || op == 2) begin
            if (dly >= WAIT_MAX) begin
                nmem = WAIT_MAX;
                tmo  = 1'b1;
            end else begin
                nmem = dly + 1;
            end
        end
`else
        exp_mem = exp_mem_n;
`endif
        e = idle(); e.ir_load = 1'b1; e.pc_write = 1'b1;
        step(e, op, mmv, ~st & 15, 1'b0);
        step(idle(), op, mmv, ~st & 15, 1'b0);
        if (op == 15) return;
        // IR is cleared from here on; the latched copy must drive decode.
        e = idle();
        e.alu_op = alu_of(op, mmv);
        if (taken_of(op, mmv, st)) begin
            e.pc_write = 1'b1;
            e.pc_sel   = (op == 4 || op == 6) ? 2'd1 : 2'd2;
        end
        step(e, 0, 0, st, 1'b0);
        for (int i = 0; i < nmem; i++) begin
            e = idle();
            e.alu_op = alu_of(op, mmv);
            e.mem_re = (op == 1);
            e.mem_we = (op == 2);
`ifdef CTRL_MEM_WAIT_EN
            step(e, 0, 0, st ^ 5, (i == dly) && (op == 1 || op == 2));
`else
            step(e, 0, 0, st ^ 5, 1'b0);
`endif
        end
        if (tmo) begin
            m_err = 1'b1;
        end else begin
            e = idle();
            e.rf_we  = (op == 8 || op == 1 || op == 3);
            e.wb_sel = (op == 1);
            step(e, 0, 0, 0, 1'b0);
            if (op == 3) begin
                e = idle(); e.rf_we = 1'b1; e.swp_phase = 1'b1;
                step(e, 0, 0, 0, 1'b0);
            end
        end
        @(negedge clk); #1;
        lit($sformatf("mem_cycles op%0d", op), n_mem - m0, exp_mem);
        if (!tmo) lit($sformatf("rf_we_cycles op%0d", op), n_rfwe - rf0, exp_rf);
    endtask

    initial begin
        outs_t e;
        do_reset();
        run_instr(8, 0, 0, 0, 1, 0, 0);
        run_instr(8, 8, 0, 0, 1, 0, 0);
        run_instr(6, 1, 0, 0, 0, 0, 0);
        run_instr(6, 1, 1, 0, 0, 0, 0);
        run_instr(4, 0, 0, 0, 0, 0, 0);
        run_instr(4, 2, 1, 0, 0, 0, 0);
        run_instr(5, 6, 4, 0, 0, 0, 0);
        run_instr(7, 2, 2, 0, 0, 0, 0);
        run_instr(7, 2, 1, 0, 0, 0, 0);
        run_instr(3, 0, 0, 0, 2, 0, 0);
        run_instr(1, 0, 3, 3, 1, 4, 1);
        run_instr(2, 0, 0, 0, 0, 1, 1);
        run_instr(1, 0, 0, 14, 1, 15, 1);
        run_instr(0, 0, 0, 0, 0, 0, 0);

        // STR interrupted by reset in MEM.
        e = idle(); e.ir_load = 1'b1; e.pc_write = 1'b1;
        step(e, 2, 0, 0, 1'b0);
        step(idle(), 2, 0, 0, 1'b0);
        e = idle(); e.alu_op = 2'b01;
        step(e, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        #1; lit("str_mem_we", int'(mem_we), 1);
        #1; rst = 1'b1;
        #1; lit("rst_mem_we", int'(mem_we), 0);
        lit("rst_alu_op", int'(alu_op), 2);
        m_err = 1'b0;
        q.push_back(idle());
        reset_tail();
        run_instr(8, 8, 0, 0, 1, 0, 0);

        // LOD that never sees ready.
        run_instr(1, 0, 0, 40, 1, WAIT_MAX, 1);
`ifdef CTRL_MEM_WAIT_EN
        hold_halt(3);
        #1;
        lit("timeout_err", int'(err), 1);
        lit("timeout_halted", int'(halted), 1);
`endif
        do_reset();

        run_instr(15, 0, 0, 0, 0, 0, 0);
        hold_halt(5);
        #1;
        lit("hlt_halted", int'(halted), 1);
        lit("hlt_ir_load", int'(ir_load), 0);
        lit("hlt_err", int'(err), 0);

        @(negedge clk); #1;
        lit("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
